serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared widths and FSM encoding for the bit-serial subtractor.
// Imported by the top module.
package serial_subtractor_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bi, with bo as the borrow out.
// Purely combinational; it holds no state.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Computes a - b - bin one bit per clock, LSB first.
// The datapath uses a single full_subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic             bout,
    output logic [RES_W-1:0] d
);

    state_t             state_reg,  state_next;
    logic [OP_W-1:0]    a_reg,      a_next;
    logic [OP_W-1:0]    b_reg,      b_next;
    logic               borrow_reg, borrow_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [OP_W-1:0]    shift_reg,  shift_next;
    logic [RES_W-1:0]   d_reg,      d_next;
    logic               bout_reg,   bout_next;
    logic               cell_diff,  cell_bo;

    // Operands shift right, so the current bit is always at position 0.
    full_subtractor u_cell (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bi   (borrow_reg),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        borrow_next = borrow_reg;
        cnt_next    = cnt_reg;
        shift_next  = shift_reg;
        d_next      = d_reg;
        bout_next   = bout_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                    cnt_next    = '0;
                    shift_next  = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                borrow_next = cell_bo;
                // Diff bits enter at the MSB so bit 0 lands at position 0 after the last shift.
                shift_next  = {cell_diff, shift_reg[OP_W-1:1]};
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(OP_W - 1)) begin
                    d_next     = RES_W'({cell_bo, cell_diff, shift_reg[OP_W-1:1]});
                    bout_next  = cell_bo;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_next;
            shift_reg  <= shift_next;
            d_reg      <= d_next;
            bout_reg   <= bout_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign bout = bout_reg;
    assign d    = d_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks for serial_subtractor.
// Inputs change #1 after each rising edge; outputs are sampled at the same point.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic       bout;
    logic [7:0] d;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_d = 8'h00;

    serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bout  (bout),
        .d     (d)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation in the current cycle and follows it through to IDLE.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                          input logic [7:0] exp_d, input string tag);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        step();
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
        for (int c = 1; c <= 4; c++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            check({tag, " d_hold"}, 32'(d), 32'(last_d));
            if (c < 4) step();
        end
        step();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_off"}, 32'(busy), 32'd0);
        check({tag, " d"}, 32'(d), 32'(exp_d));
        check({tag, " bout"}, 32'(bout), 32'(exp_d[4]));
        $display("op %s a=%0h b=%0h bin=%0b d=%02h bout=%0b", tag, ta, tb, tbin, d, bout);
        last_d = exp_d;
        step();
        check({tag, " done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst d", 32'(d), 32'd0);
        check("rst bout", 32'(bout), 32'd0);
        rst = 1'b0;
        step();

        run_op(4'd9, 4'd3, 1'b0, 8'h06, "v9m3");
        run_op(4'd3, 4'd9, 1'b0, 8'h1A, "v3m9");
        run_op(4'd0, 4'd0, 1'b1, 8'h1F, "v0m0b1");

        // Start while running is dropped; start during DONE is dropped; start in IDLE is taken.
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        check("ign c1 busy", 32'(busy), 32'd1);
        step();                                   // cycle 2
        a = 4'd15; b = 4'd0; start = 1'b1;
        step();                                   // cycle 3
        start = 1'b0;
        check("ign c3 busy", 32'(busy), 32'd1);
        step();                                   // cycle 4
        check("ign c4 done", 32'(done), 32'd0);
        step();                                   // cycle 5
        check("ign c5 done", 32'(done), 32'd1);
        check("ign c5 d", 32'(d), 32'h06);
        start = 1'b1;
        step();                                   // cycle 6
        check("ign c6 busy", 32'(busy), 32'd0);
        check("ign c6 done", 32'(done), 32'd0);
        step();                                   // cycle 7
        start = 1'b0;
        check("ign c7 busy", 32'(busy), 32'd1);
        check("ign c7 d_hold", 32'(d), 32'h06);
        for (int c = 8; c <= 10; c++) begin
            step();
            check("ign run done", 32'(done), 32'd0);
        end
        step();                                   // cycle 11
        check("ign c11 done", 32'(done), 32'd1);
        check("ign c11 d", 32'(d), 32'h0F);
        $display("op ignore_start second d=%02h", d);
        last_d = 8'h0F;
        step();

        // Reset mid-operation aborts with no done pulse and clears the result.
        a = 4'd15; b = 4'd1; bin = 1'b0; start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        step();                                   // cycle 2
        check("abort c2 busy", 32'(busy), 32'd1);
        step();                                   // cycle 3
        rst = 1'b1;
        step();                                   // cycle 4
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort d", 32'(d), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        for (int c = 0; c < 8; c++) begin
            check("abort no_done", 32'(done), 32'd0);
            step();
        end
        $display("op abort d=%02h", d);
        last_d = 8'h00;
        run_op(4'd15, 4'd1, 1'b0, 8'h0E, "after_abort");

        for (int i = 0; i < 512; i++) begin
            logic [3:0] ta;
            logic [3:0] tb;
            logic       tbin;
            int         r;
            ta   = 4'(i);
            tb   = 4'(i >> 4);
            tbin = i[8];
            r    = (int'(ta) - int'(tb) - int'(tbin)) & 31;
            run_op(ta, tb, tbin, 8'(r), $sformatf("ex%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
